// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side handoff.
// The fetch unit is the master; memory and decode together form the slave side.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, opcode, funct,
        input  imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, opcode, funct,
        output imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: one memory read per instruction,
// holds the captured word for decode and squashes in-flight reads on redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        instr_valid_q;
    logic        kill;
    logic        capture;
    logic [31:0] target;

    // Masking instead of slicing keeps every redirect_pc bit in use.
    assign target  = bus.redirect_pc & ~32'h0000_0003;
    assign capture = (state == ST_WAIT) && bus.imem_rvalid && !kill && !bus.redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_next = (kill || bus.redirect) ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.redirect || !bus.stall) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state == ST_REQ);
        bus.imem_addr   = fetch_pc;
        bus.instr       = instr_q;
        bus.instr_valid = instr_valid_q;
        bus.pc          = pc_q;
        bus.pc_plus4    = pc_q + 32'd4;
        bus.opcode      = instr_q[31:26];
        bus.funct       = instr_q[5:0];
    end

    // kill marks the single outstanding response as belonging to a stale address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            kill          <= 1'b0;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= target;
            end else if (capture) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (capture) begin
                instr_q <= bus.imem_rdata;
                pc_q    <= fetch_pc;
            end

            if (capture) begin
                instr_valid_q <= 1'b1;
            end else if ((state == ST_HOLD) && (bus.redirect || !bus.stall)) begin
                instr_valid_q <= 1'b0;
            end else if ((state == ST_IDLE) && bus.redirect) begin
                instr_valid_q <= 1'b0;
            end

            case (state)
                ST_REQ: begin
                    if (bus.redirect) begin
                        kill <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        kill <= 1'b0;
                    end else if (bus.redirect) begin
                        kill <= 1'b1;
                    end
                end
                default: kill <= kill;
            endcase
        end
    end

endmodule
